// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver and its consumers.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  localparam int PS2_DATA_BITS = 8;

  localparam logic [7:0] SC_BREAK    = 8'hF0;
  localparam logic [7:0] SC_EXTENDED = 8'hE0;

  // Odd parity holds when data plus parity bit carry an odd number of ones.
  function automatic logic odd_parity_ok(input logic [PS2_DATA_BITS-1:0] data,
                                         input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_teclado_fifo_if.sv
// CPU-side read bus of the keyboard FIFO: pop/clear requests in, head byte and status out.
interface ps2_teclado_fifo_if #(
  parameter int FIFO_DEPTH = 8
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          ReadEnable;
  logic          ClearErrors;
  logic [7:0]    DataOut;
  logic          Empty;
  logic          Full;
  logic [CW-1:0] Count;
  logic          FrameError;
  logic          Overflow;

  modport master (
    output ReadEnable, ClearErrors,
    input  DataOut, Empty, Full, Count, FrameError, Overflow
  );

  modport slave (
    input  ReadEnable, ClearErrors,
    output DataOut, Empty, Full, Count, FrameError, Overflow
  );

endinterface

// File: rtl/ps2_fifo.sv
// Generic synchronous show-ahead FIFO with sticky overflow flag; head is read straight from storage.
module ps2_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  input  logic                     clear_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             pop_en, push_en, ovf_set;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];
  assign overflow = overflow_q;

  // When full, a simultaneous pop frees the slot the push lands in.
  assign pop_en  = pop & ~empty;
  assign push_en = push & (~full | pop_en);
  assign ovf_set = push & full & ~pop_en;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (push_en) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_en)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push_en && !pop_en)      count_d = count_q + CW'(1);
    else if (pop_en && !push_en) count_d = count_q - CW'(1);
    if (ovf_set)             overflow_d = 1'b1;
    else if (clear_overflow) overflow_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      if (push_en) mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/ps2_teclado_fifo.sv
// PS/2 keyboard frame receiver feeding a scancode FIFO read by the CPU input stage.
//   state     | meaning
//   ST_IDLE   | bus idle, waiting for a start bit (data=0 on a falling edge)
//   ST_DATA   | shifting in 8 data bits, LSB first
//   ST_PARITY | next edge carries the odd parity bit
//   ST_STOP   | next edge carries the stop bit; frame checked and pushed
module ps2_teclado_fifo
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 ps2_clk,
  input  logic                 ps2_data,
  ps2_teclado_fifo_if.slave    bus
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int BW = $clog2(PS2_DATA_BITS);

  logic clk_s1_q, clk_s2_q, clk_prev_q;
  logic dat_s1_q, dat_s2_q;
  logic fall_edge;

  ps2_state_e               state_q;
  logic [BW-1:0]            bit_cnt_q;
  logic [PS2_DATA_BITS-1:0] shift_q;
  logic                     parity_q;
  logic [TW-1:0]            tmo_q;
  logic                     frame_error_q;
  logic                     frame_ok;
  logic                     push;

  // Synchronisers idle high so reset never fabricates a falling edge.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
    end else begin
      clk_s1_q   <= ps2_clk;
      clk_s2_q   <= clk_s1_q;
      clk_prev_q <= clk_s2_q;
      dat_s1_q   <= ps2_data;
      dat_s2_q   <= dat_s1_q;
    end
  end

  assign fall_edge = clk_prev_q & ~clk_s2_q;
  assign frame_ok  = dat_s2_q & odd_parity_ok(shift_q, parity_q);
  assign push      = (state_q == ST_STOP) & fall_edge & frame_ok;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q       <= ST_IDLE;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      parity_q      <= 1'b0;
      tmo_q         <= '0;
      frame_error_q <= 1'b0;
    end else begin
      frame_error_q <= 1'b0;
      if (state_q == ST_IDLE) begin
        tmo_q <= '0;
        if (fall_edge && !dat_s2_q) begin
          state_q   <= ST_DATA;
          bit_cnt_q <= '0;
        end
      end else if (fall_edge) begin
        tmo_q <= '0;
        case (state_q)
          ST_DATA: begin
            shift_q   <= {dat_s2_q, shift_q[PS2_DATA_BITS-1:1]};
            bit_cnt_q <= bit_cnt_q + BW'(1);
            if (bit_cnt_q == BW'(PS2_DATA_BITS - 1)) state_q <= ST_PARITY;
          end
          ST_PARITY: begin
            parity_q <= dat_s2_q;
            state_q  <= ST_STOP;
          end
          ST_STOP: begin
            if (!frame_ok) frame_error_q <= 1'b1;
            state_q <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
        // Sender stalled mid-frame: abandon the partial byte.
        state_q       <= ST_IDLE;
        tmo_q         <= '0;
        frame_error_q <= 1'b1;
      end else begin
        tmo_q <= tmo_q + TW'(1);
      end
    end
  end

  ps2_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PS2_DATA_BITS)
  ) u_fifo (
    .clk            (Clock),
    .rst            (Reset),
    .push           (push),
    .push_data      (shift_q),
    .pop            (bus.ReadEnable),
    .head           (bus.DataOut),
    .empty          (bus.Empty),
    .full           (bus.Full),
    .count          (bus.Count),
    .overflow       (bus.Overflow),
    .clear_overflow (bus.ClearErrors)
  );

  assign bus.FrameError = frame_error_q;

endmodule

// File: tb/tb_ps2_teclado_fifo.sv
// Self-checking bench for the PS/2 keyboard FIFO: vector table, corner sequences, random frames vs a queue model.
module tb_ps2_teclado_fifo;
  import ps2_pkg::*;

  localparam int DEPTH = 8;
  localparam int TMO   = 300;
  localparam int H     = 20;

  logic Clock = 1'b0;
  logic Reset;
  logic ps2_clk;
  logic ps2_data;

  ps2_teclado_fifo_if #(.FIFO_DEPTH(DEPTH)) bus ();

  ps2_teclado_fifo #(
    .FIFO_DEPTH     (DEPTH),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .bus      (bus)
  );

  always #5 Clock = ~Clock;

  int compared   = 0;
  int mismatched = 0;
  int ferr_cnt   = 0;

  always @(negedge Clock) if (bus.FrameError) ferr_cnt++;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int actual, input int expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge Clock);
  endtask

  function automatic logic [10:0] frame_bits(input logic [7:0] b, input bit bad_par,
                                             input bit bad_stop);
    logic [10:0] f;
    f[0]   = 1'b0;
    f[8:1] = b;
    f[9]   = (~^b) ^ bad_par;
    f[10]  = ~bad_stop;
    return f;
  endfunction

  task automatic send_bits(input logic [10:0] f, input int first, input int last);
    for (int i = first; i <= last; i++) begin
      ps2_data = f[i];
      tick(H);
      ps2_clk = 1'b0;
      tick(H);
      ps2_clk = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    send_bits(frame_bits(b, bad_par, bad_stop), 0, 10);
    tick(H);
  endtask

  task automatic pop1();
    bus.ReadEnable = 1'b1;
    tick(1);
    bus.ReadEnable = 1'b0;
    tick(1);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    tick(2);
    Reset = 1'b0;
    tick(2);
  endtask

  typedef struct {
    logic [7:0] data;
    bit         bad_par;
    bit         bad_stop;
    bit         pop_after;
    int         exp_count;
    logic [7:0] exp_head;
    int         exp_ferr;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int f0;
    int waited;
    bit seen;
    logic [10:0] fb;
    logic [7:0] model_q[$];
    bit model_ovf;

    Reset = 1'b1;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    bus.ReadEnable = 1'b0;
    bus.ClearErrors = 1'b0;
    tick(3);
    check("rst_count", int'(bus.Count), 0);
    check("rst_empty", int'(bus.Empty), 1);
    check("rst_full", int'(bus.Full), 0);
    check("rst_dataout", int'(bus.DataOut), 0);
    check("rst_ferr", int'(bus.FrameError), 0);
    check("rst_ovf", int'(bus.Overflow), 0);
    Reset = 1'b0;
    tick(2);

    // Latency of a valid 8'h1C frame, then pop
    fb = frame_bits(8'h1C, 0, 0);
    send_bits(fb, 0, 9);
    ps2_data = fb[10];
    tick(H);
    ps2_clk = 1'b0;
    tick(2);
    check("lat_empty_c2", int'(bus.Empty), 1);
    tick(1);
    check("lat_empty_c3", int'(bus.Empty), 0);
    check("lat_data", int'(bus.DataOut), 8'h1C);
    check("lat_count", int'(bus.Count), 1);
    tick(H);
    ps2_clk = 1'b1;
    tick(H);
    pop1();
    check("pop_empty", int'(bus.Empty), 1);
    check("pop_count", int'(bus.Count), 0);

    // Bad parity: exactly one-cycle FrameError, no push
    fb = frame_bits(8'h1C, 1, 0);
    send_bits(fb, 0, 9);
    ps2_data = fb[10];
    tick(H);
    ps2_clk = 1'b0;
    tick(2);
    check("par_ferr_c2", int'(bus.FrameError), 0);
    tick(1);
    check("par_ferr_c3", int'(bus.FrameError), 1);
    tick(1);
    check("par_ferr_c4", int'(bus.FrameError), 0);
    tick(H);
    ps2_clk = 1'b1;
    tick(H);
    check("par_count", int'(bus.Count), 0);
    send_frame(8'h32, 0, 0);
    check("after_par_data", int'(bus.DataOut), 8'h32);
    check("after_par_count", int'(bus.Count), 1);
    pop1();

    // Timeout after start + 4 data bits
    f0 = ferr_cnt;
    send_bits(frame_bits(8'hA5, 0, 0), 0, 4);
    ps2_data = 1'b1;
    seen = 0;
    waited = 0;
    while (!seen && waited < TMO + 100) begin
      tick(1);
      waited++;
      if (bus.FrameError) seen = 1;
    end
    check("tmo_ferr_seen", int'(seen), 1);
    check("tmo_count", int'(bus.Count), 0);
    tick(5);
    send_frame(SC_BREAK, 0, 0);
    check("tmo_next_data", int'(bus.DataOut), SC_BREAK);
    check("tmo_next_count", int'(bus.Count), 1);
    check("tmo_ferr_total", ferr_cnt - f0, 1);
    do_reset();

    // Overflow: 9 frames, no reads
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 0, 0);
    check("ovf_count", int'(bus.Count), 8);
    check("ovf_full", int'(bus.Full), 1);
    check("ovf_flag", int'(bus.Overflow), 1);
    check("ovf_head", int'(bus.DataOut), 1);
    for (int i = 1; i <= 8; i++) begin
      check("ovf_pop_data", int'(bus.DataOut), i);
      pop1();
    end
    check("ovf_drained", int'(bus.Empty), 1);
    check("ovf_still_set", int'(bus.Overflow), 1);
    bus.ClearErrors = 1'b1;
    tick(1);
    bus.ClearErrors = 1'b0;
    tick(1);
    check("ovf_cleared", int'(bus.Overflow), 0);

    // Full FIFO, push and pop in the same cycle
    for (int i = 1; i <= 8; i++) send_frame(8'(i), 0, 0);
    fb = frame_bits(8'h77, 0, 0);
    send_bits(fb, 0, 9);
    ps2_data = fb[10];
    tick(H);
    ps2_clk = 1'b0;
    tick(2);
    bus.ReadEnable = 1'b1;
    tick(1);
    bus.ReadEnable = 1'b0;
    check("pp_count", int'(bus.Count), 8);
    check("pp_ovf", int'(bus.Overflow), 0);
    check("pp_head", int'(bus.DataOut), 2);
    tick(H);
    ps2_clk = 1'b1;
    tick(H);
    for (int i = 2; i <= 8; i++) pop1();
    check("pp_new_byte", int'(bus.DataOut), 8'h77);
    check("pp_last_count", int'(bus.Count), 1);

    // Reset mid-frame with FIFO occupied
    send_bits(frame_bits(8'hAA, 0, 0), 0, 4);
    Reset = 1'b1;
    tick(2);
    check("mid_rst_count", int'(bus.Count), 0);
    check("mid_rst_empty", int'(bus.Empty), 1);
    check("mid_rst_data", int'(bus.DataOut), 0);
    check("mid_rst_full", int'(bus.Full), 0);
    check("mid_rst_ovf", int'(bus.Overflow), 0);
    Reset = 1'b0;
    tick(2);
    f0 = ferr_cnt;
    send_frame(8'h55, 0, 0);
    check("mid_rst_next", int'(bus.DataOut), 8'h55);
    check("mid_rst_ferr", ferr_cnt - f0, 0);
    do_reset();

    // Vector table from an empty FIFO
    tbl[0] = '{8'h1C, 0, 0, 0, 1, 8'h1C, 0};
    tbl[1] = '{8'h32, 1, 0, 0, 1, 8'h1C, 1};
    tbl[2] = '{8'h32, 0, 0, 0, 2, 8'h1C, 0};
    tbl[3] = '{8'hF0, 0, 1, 0, 2, 8'h1C, 1};
    tbl[4] = '{8'hF0, 0, 0, 1, 2, 8'h32, 0};
    tbl[5] = '{8'hE0, 0, 0, 1, 2, 8'hF0, 0};
    tbl[6] = '{8'hAA, 0, 0, 0, 3, 8'hF0, 0};
    for (int i = 0; i < 7; i++) begin
      f0 = ferr_cnt;
      send_frame(tbl[i].data, tbl[i].bad_par, tbl[i].bad_stop);
      if (tbl[i].pop_after) pop1();
      check("tbl_count", int'(bus.Count), tbl[i].exp_count);
      check("tbl_head", int'(bus.DataOut), int'(tbl[i].exp_head));
      check("tbl_ferr", ferr_cnt - f0, tbl[i].exp_ferr);
    end
    do_reset();

    // Random frames against a queue model
    model_q.delete();
    model_ovf = 0;
    for (int n = 0; n < 40; n++) begin
      logic [7:0] b;
      bit bp, bs;
      b  = 8'($urandom);
      bp = ($urandom_range(0, 5) == 0);
      bs = ($urandom_range(0, 7) == 0);
      f0 = ferr_cnt;
      send_frame(b, bp, bs);
      if (!bp && !bs) begin
        if (model_q.size() < DEPTH) model_q.push_back(b);
        else model_ovf = 1;
      end
      check("rnd_ferr", ferr_cnt - f0, (bp || bs) ? 1 : 0);
      if ($urandom_range(0, 2) == 0) begin
        pop1();
        if (model_q.size() > 0) void'(model_q.pop_front());
      end
      if ($urandom_range(0, 5) == 0) begin
        bus.ClearErrors = 1'b1;
        tick(1);
        bus.ClearErrors = 1'b0;
        tick(1);
        model_ovf = 0;
      end
      check("rnd_count", int'(bus.Count), model_q.size());
      check("rnd_empty", int'(bus.Empty), (model_q.size() == 0) ? 1 : 0);
      check("rnd_full", int'(bus.Full), (model_q.size() == DEPTH) ? 1 : 0);
      check("rnd_ovf", int'(bus.Overflow), int'(model_ovf));
      if (model_q.size() > 0) check("rnd_head", int'(bus.DataOut), int'(model_q[0]));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
